powlib_downfifo: RTL and testbench

- Single-clock width-downsizing FIFO. Accepts words of W*MULT bits and emits them as MULT consecutive W-bit words, least-significant slice first.
- Used in powlib streaming datapaths wherever a wide producer feeds a narrow consumer.
- Structure: a D-entry wide buffer FIFO followed by a serializer stage. Both sides use valid/ready handshakes.

---
 rtl/powlib_downfifo_if.sv | 22 ++
 rtl/powlib_downfifo.sv | 104 ++++++++++
 tb/tb_powlib_downfifo.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/powlib_downfifo_if.sv
// Handshake bundle for powlib_downfifo: wide write stream in, narrow read stream out.
interface powlib_downfifo_if #(
    parameter int unsigned W    = 32,
    parameter int unsigned MULT = 2
);
    logic [W*MULT-1:0] wrdata;
    logic              wrvld;
    logic              wrrdy;
    logic [W-1:0]      rddata;
    logic              rdvld;
    logic              rdrdy;

    modport slave (
        input  wrdata, wrvld, rdrdy,
        output wrrdy, rddata, rdvld
    );

    modport master (
        output wrdata, wrvld, rdrdy,
        input  wrrdy, rddata, rdvld
    );
endinterface

// File: rtl/powlib_downfifo.sv
// Width-downsizing FIFO: D-entry wide buffer feeding a shift-out serializer that
// emits each W*MULT word as MULT W-bit slices, low slice first.
module powlib_downfifo #(
    parameter int unsigned W      = 32,
    parameter int unsigned MULT   = 2,
    parameter int unsigned D      = 8,
    parameter int unsigned EASYNC = 0,
    parameter int unsigned EAR    = 0,
    parameter              ID     = "DOWNFIFO",
    parameter int unsigned EDBG   = 0
) (
    input logic              clk,
    input logic              rst,
    powlib_downfifo_if.slave bus
);
    localparam int unsigned WW = W * MULT;
    localparam int unsigned PW = $clog2(D);
    localparam int unsigned CW = $clog2(D + 1);
    localparam int unsigned KW = (MULT > 1) ? $clog2(MULT) : 1;

    logic [WW-1:0] mem_q [D];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          wrrdy_q,  wrrdy_d;
    logic [WW-1:0] ser_q,    ser_d;
    logic [KW-1:0] k_q,      k_d;
    logic          vld_q,    vld_d;

    logic push_c;
    logic xfer_c;
    logic last_c;
    logic pop_c;

    // Compatibility-only parameters: the block is always single-clock, sync reset.
    logic unused_cfg_c;
    assign unused_cfg_c = ^{32'(EASYNC), 32'(EAR), 32'(EDBG), 32'($bits(ID))};

    assign push_c = bus.wrvld & wrrdy_q;
    assign xfer_c = vld_q & bus.rdrdy;
    assign last_c = xfer_c & (k_q == KW'(MULT - 1));
    // Reload the serializer when empty or when its final slice leaves this cycle.
    assign pop_c  = (~vld_q | last_c) & (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ser_d    = ser_q;
        k_d      = k_q;
        vld_d    = vld_q;

        if (push_c) begin
            wr_ptr_d = (wr_ptr_q == PW'(D - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (pop_c) begin
            rd_ptr_d = (rd_ptr_q == PW'(D - 1)) ? '0 : rd_ptr_q + PW'(1);
        end

        count_d = count_q + CW'(push_c) - CW'(pop_c);
        wrrdy_d = (count_d < CW'(D));

        // Slice 0 always sits in the low bits, so rddata comes straight off a register.
        if (xfer_c) begin
            ser_d = ser_q >> W;
            k_d   = last_c ? '0 : k_q + KW'(1);
            vld_d = ~last_c;
        end
        if (pop_c) begin
            ser_d = mem_q[rd_ptr_q];
            k_d   = '0;
            vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            wrrdy_q  <= 1'b1;
            ser_q    <= '0;
            k_q      <= '0;
            vld_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            wrrdy_q  <= wrrdy_d;
            ser_q    <= ser_d;
            k_q      <= k_d;
            vld_q    <= vld_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= bus.wrdata;
        end
    end

    assign bus.wrrdy  = wrrdy_q;
    assign bus.rdvld  = vld_q;
    assign bus.rddata = ser_q[W-1:0];
endmodule

// File: tb/tb_powlib_downfifo.sv
// Directed and randomized checks for powlib_downfifo (W=16, MULT=3, D=4) plus a MULT=1 instance.
module tb_powlib_downfifo;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    powlib_downfifo_if #(.W(16), .MULT(3)) dif_a ();
    powlib_downfifo_if #(.W(16), .MULT(1)) dif_b ();

    powlib_downfifo #(.W(16), .MULT(3), .D(4), .ID("DUT_A")) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (dif_a.slave)
    );

    powlib_downfifo #(.W(16), .MULT(1), .D(2), .ID("DUT_B")) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (dif_b.slave)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_push   = 0;
    logic [15:0] model [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle on DUT A: score the output transfer, log the input transfer, advance.
    task automatic step(output bit pushed, output bit popped);
        logic [47:0] w;
        pushed = 1'b0;
        popped = 1'b0;
        if (dif_a.rdvld && dif_a.rdrdy) begin
            popped = 1'b1;
            if (model.size() == 0) begin
                chk("pop_unexpected", 64'(dif_a.rddata), 64'hDEAD_0000);
            end else begin
                chk("pop_data", 64'(dif_a.rddata), 64'(model.pop_front()));
            end
        end
        if (dif_a.wrvld && dif_a.wrrdy) begin
            pushed = 1'b1;
            n_push++;
            w = dif_a.wrdata;
            model.push_back(w[15:0]);
            model.push_back(w[31:16]);
            model.push_back(w[47:32]);
        end
        tick();
    endtask

    task automatic drain_a(input string tag);
        bit pu, po;
        dif_a.wrvld = 1'b0;
        dif_a.rdrdy = 1'b1;
        for (int c = 0; c < 200 && model.size() > 0; c++) step(pu, po);
        chk({tag, "_drained"}, 64'(model.size()), 64'd0);
        tick();
        chk({tag, "_idle_vld"}, 64'(dif_a.rdvld), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [47:0] words [4];
        bit pu, po;
        int idx, nout, first, last;

        dif_a.wrdata = '0; dif_a.wrvld = 1'b0; dif_a.rdrdy = 1'b0;
        dif_b.wrdata = '0; dif_b.wrvld = 1'b0; dif_b.rdrdy = 1'b0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;

        chk("rst_rdvld", 64'(dif_a.rdvld), 64'd0);
        chk("rst_rddata", 64'(dif_a.rddata), 64'd0);
        chk("rst_wrrdy", 64'(dif_a.wrrdy), 64'd1);
        chk("rst_b_wrrdy", 64'(dif_b.wrrdy), 64'd1);

        // Basic split with one-cycle load latency
        dif_a.wrdata = 48'h3333_2222_1111;
        dif_a.wrvld  = 1'b1;
        dif_a.rdrdy  = 1'b1;
        tick();
        dif_a.wrvld  = 1'b0;
        chk("t1_lat_vld", 64'(dif_a.rdvld), 64'd0);
        tick();
        chk("t1_vld0", 64'(dif_a.rdvld), 64'd1);
        chk("t1_s0", 64'(dif_a.rddata), 64'h1111);
        tick();
        chk("t1_s1", 64'(dif_a.rddata), 64'h2222);
        tick();
        chk("t1_s2", 64'(dif_a.rddata), 64'h3333);
        tick();
        chk("t1_done", 64'(dif_a.rdvld), 64'd0);

        // Streaming: 4 words, 12 contiguous output slices
        words[0] = 48'h0103_0102_0101;
        words[1] = 48'h0203_0202_0201;
        words[2] = 48'h0303_0302_0301;
        words[3] = 48'h0403_0402_0401;
        idx = 0; nout = 0; first = 0; last = 0;
        dif_a.rdrdy = 1'b1;
        for (int c = 0; c < 40; c++) begin
            dif_a.wrvld  = (idx < 4);
            dif_a.wrdata = (idx < 4) ? words[idx] : 48'h0;
            step(pu, po);
            if (po) begin
                if (nout == 0) first = c;
                last = c;
                nout++;
            end
            if (pu) idx++;
        end
        chk("t2_words_in", 64'(idx), 64'd4);
        chk("t2_nout", 64'(nout), 64'd12);
        chk("t2_span", 64'(last - first), 64'd11);
        chk("t2_empty", 64'(model.size()), 64'd0);

        // Full and backpressure: D+1 words accepted, head held stable
        n_push = 0;
        dif_a.rdrdy = 1'b0;
        dif_a.wrvld = 1'b1;
        for (int c = 0; c < 10; c++) begin
            dif_a.wrdata = {16'(16'h0A00 + 3*c + 2), 16'(16'h0A00 + 3*c + 1), 16'(16'h0A00 + 3*c)};
            step(pu, po);
            if (dif_a.rdvld) chk("t3_hold", 64'(dif_a.rddata), 64'(model[0]));
        end
        chk("t3_accepted", 64'(n_push), 64'd5);
        chk("t3_wrrdy_full", 64'(dif_a.wrrdy), 64'd0);
        chk("t3_vld", 64'(dif_a.rdvld), 64'd1);
        chk("t3_head", 64'(dif_a.rddata), 64'h0A00);
        dif_a.wrvld = 1'b0;
        dif_a.rdrdy = 1'b1;
        for (int c = 0; c < 60 && model.size() > 0; c++) begin
            if (c == 2) chk("t3_wrrdy_still_lo", 64'(dif_a.wrrdy), 64'd0);
            if (c == 3) chk("t3_wrrdy_reassert", 64'(dif_a.wrrdy), 64'd1);
            step(pu, po);
        end
        drain_a("t3");

        // Random handshake against a slice-level reference queue
        for (int c = 0; c < 1000; c++) begin
            dif_a.wrvld  = 1'($urandom_range(0, 1));
            dif_a.rdrdy  = 1'($urandom_range(0, 1));
            dif_a.wrdata = {16'($urandom), 32'($urandom)};
            step(pu, po);
        end
        drain_a("t4");

        // Reset after one of three slices has left; buffered word is discarded too
        dif_a.rdrdy  = 1'b0;
        dif_a.wrvld  = 1'b1;
        dif_a.wrdata = 48'h0000_6666_5555;
        step(pu, po);
        dif_a.wrdata = 48'h9999_8888_7777;
        step(pu, po);
        dif_a.wrvld  = 1'b0;
        chk("t5_head", 64'(dif_a.rddata), 64'h5555);
        dif_a.rdrdy  = 1'b1;
        step(pu, po);
        dif_a.rdrdy  = 1'b0;
        chk("t5_mid", 64'(dif_a.rddata), 64'h6666);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model.delete();
        chk("t5_rst_vld", 64'(dif_a.rdvld), 64'd0);
        chk("t5_rst_wrrdy", 64'(dif_a.wrrdy), 64'd1);
        tick();
        chk("t5_no_residue", 64'(dif_a.rdvld), 64'd0);
        dif_a.wrvld  = 1'b1;
        dif_a.wrdata = 48'h0000_BBBB_AAAA;
        dif_a.rdrdy  = 1'b1;
        step(pu, po);
        dif_a.wrvld  = 1'b0;
        tick();
        chk("t5_first", 64'(dif_a.rddata), 64'hAAAA);
        drain_a("t5");

        // MULT=1 behaves as a plain FIFO
        dif_b.rdrdy  = 1'b1;
        dif_b.wrvld  = 1'b1;
        dif_b.wrdata = 16'hBEEF;
        tick();
        dif_b.wrdata = 16'hCAFE;
        tick();
        dif_b.wrvld  = 1'b0;
        chk("t6_vld0", 64'(dif_b.rdvld), 64'd1);
        chk("t6_w0", 64'(dif_b.rddata), 64'hBEEF);
        tick();
        chk("t6_w1", 64'(dif_b.rddata), 64'hCAFE);
        tick();
        chk("t6_done", 64'(dif_b.rdvld), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
